// File: rtl/sonata_drp_pkg.sv
// Shared types for the MMCM DRP sequencer: FSM states, table entry layout, error codes.
// Optional build macro SONATA_DRP_SEQ_TIMEOUT_EN (default: undefined, waits are unbounded).
package sonata_drp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_ON,
    RD,
    RD_WAIT,
    WR,
    WR_WAIT,
    RST_OFF,
    LOCK_WAIT
  } drp_state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RD_TMO   = 2'd1;
  localparam logic [1:0] ERR_WR_TMO   = 2'd2;
  localparam logic [1:0] ERR_LOCK_TMO = 2'd3;

  // Value of the hold counter at which mmcm_rst has been high for 3 cycles.
  localparam logic [1:0] RST_HOLD_LAST = 2'd2;

`ifdef SONATA_DRP_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // Mask bit 1 keeps the current DRP bit, 0 takes the new data bit.
  function automatic logic [15:0] rmw_merge(input logic [15:0] cur, input logic [15:0] mask,
                                            input logic [15:0] data);
    return (cur & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level (MMCM LOCKED).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/mmcm_drp_sequencer.sv
// Runs a host-loaded table of DRP read-modify-writes with the MMCM held in reset, then waits for lock.
// Build macro SONATA_DRP_SEQ_TIMEOUT_EN adds DRDY/lock timeouts reported through error/err_code.
module mmcm_drp_sequencer
  import sonata_drp_pkg::*;
#(
  parameter int pDEPTH = 8,
  parameter int pIDX_W = $clog2(pDEPTH),
  parameter int pTMO_W = 16
) (
  input  logic              clk_usb,
  input  logic              reset_i,
  input  logic              tbl_we,
  input  logic [pIDX_W-1:0] tbl_idx,
  input  logic [6:0]        tbl_addr,
  input  logic [15:0]       tbl_mask,
  input  logic [15:0]       tbl_data,
  input  logic [pIDX_W:0]   cfg_count,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [6:0]        drp_addr,
  output logic [15:0]       drp_din,
  output logic              drp_den,
  output logic              drp_dwe,
  input  logic [15:0]       drp_dout,
  input  logic              drp_drdy,
  output logic              mmcm_rst,
  input  logic              mmcm_locked
);

  localparam logic [pIDX_W:0] DEPTH_L = (pIDX_W + 1)'(pDEPTH);

  drp_state_e          state_reg;
  logic [pIDX_W:0]     n_reg;
  logic [pIDX_W-1:0]   idx_reg;
  logic [1:0]          rst_hold_reg;
  logic                lock_sync;
  logic                tmo_hit;
  logic [pIDX_W:0]     n_clamped;
  drp_entry_t          entry;
  drp_entry_t          tbl_mem [pDEPTH];

  always_ff @(posedge clk_usb) begin
    if (tbl_we && !busy) begin
      tbl_mem[tbl_idx] <= '{addr: tbl_addr, mask: tbl_mask, data: tbl_data};
    end
  end

  assign entry     = tbl_mem[idx_reg];
  assign n_clamped = (cfg_count > DEPTH_L) ? DEPTH_L : cfg_count;

  sync_2ff u_lock_sync (
    .clk (clk_usb),
    .rst (reset_i),
    .d   (mmcm_locked),
    .q   (lock_sync)
  );

`ifdef SONATA_DRP_SEQ_TIMEOUT_EN
  // Counter restarts on every state entry; tmo_cur is the cycle count within the current state.
  logic [pTMO_W-1:0] tmo_reg;
  logic [pTMO_W-1:0] tmo_cur;
  drp_state_e        state_prev_reg;

  assign tmo_cur = (state_reg != state_prev_reg) ? '0 : tmo_reg;
  assign tmo_hit = TIMEOUT_EN && (tmo_cur == '1);

  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      tmo_reg        <= '0;
      state_prev_reg <= IDLE;
    end else begin
      state_prev_reg <= state_reg;
      tmo_reg        <= (tmo_cur == '1) ? tmo_cur : tmo_cur + pTMO_W'(1);
    end
  end
`else
  // Without the timeout option the waits never expire.
  assign tmo_hit = TIMEOUT_EN && (pTMO_W < 0);
`endif

  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      state_reg    <= IDLE;
      n_reg        <= '0;
      idx_reg      <= '0;
      rst_hold_reg <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      drp_addr     <= '0;
      drp_din      <= '0;
      drp_den      <= 1'b0;
      drp_dwe      <= 1'b0;
      mmcm_rst     <= 1'b0;
    end else begin
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;
      if (mmcm_rst && rst_hold_reg != 2'd3) rst_hold_reg <= rst_hold_reg + 2'd1;

      case (state_reg)
        IDLE: if (start) begin
          busy      <= 1'b1;
          done      <= 1'b0;
          error     <= 1'b0;
          err_code  <= ERR_NONE;
          n_reg     <= n_clamped;
          idx_reg   <= '0;
          state_reg <= RST_ON;
        end
        RST_ON: begin
          mmcm_rst     <= 1'b1;
          rst_hold_reg <= '0;
          state_reg    <= (n_reg == '0) ? RST_OFF : RD;
        end
        RD: begin
          drp_den   <= 1'b1;
          drp_addr  <= entry.addr;
          state_reg <= RD_WAIT;
        end
        RD_WAIT: begin
          if (drp_drdy) begin
            drp_din   <= rmw_merge(drp_dout, entry.mask, entry.data);
            state_reg <= WR;
          end else if (tmo_hit) begin
            error     <= 1'b1;
            err_code  <= ERR_RD_TMO;
            mmcm_rst  <= 1'b0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        WR: begin
          drp_den   <= 1'b1;
          drp_dwe   <= 1'b1;
          state_reg <= WR_WAIT;
        end
        WR_WAIT: begin
          if (drp_drdy) begin
            idx_reg   <= idx_reg + pIDX_W'(1);
            state_reg <= ({1'b0, idx_reg} == n_reg - (pIDX_W + 1)'(1)) ? RST_OFF : RD;
          end else if (tmo_hit) begin
            error     <= 1'b1;
            err_code  <= ERR_WR_TMO;
            mmcm_rst  <= 1'b0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        RST_OFF: if (rst_hold_reg >= RST_HOLD_LAST) begin
          mmcm_rst  <= 1'b0;
          state_reg <= LOCK_WAIT;
        end
        LOCK_WAIT: begin
          if (lock_sync) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= IDLE;
          end else if (tmo_hit) begin
            error     <= 1'b1;
            err_code  <= ERR_LOCK_TMO;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Self-checking bench for mmcm_drp_sequencer with a behavioural DRP/MMCM model and RMW reference model.
// Timeout scenarios run only when SONATA_DRP_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mmcm_drp_sequencer;
  import sonata_drp_pkg::*;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int TMO_W = 10;

  logic             clk_usb = 1'b0;
  logic             reset_i = 1'b1;
  logic             tbl_we = 1'b0;
  logic [IDX_W-1:0] tbl_idx = '0;
  logic [6:0]       tbl_addr = '0;
  logic [15:0]      tbl_mask = '0;
  logic [15:0]      tbl_data = '0;
  logic [IDX_W:0]   cfg_count = '0;
  logic             start = 1'b0;
  logic             busy, done, error;
  logic [1:0]       err_code;
  logic [6:0]       drp_addr;
  logic [15:0]      drp_din;
  logic             drp_den, drp_dwe;
  logic [15:0]      drp_dout = '0;
  logic             drp_drdy = 1'b0;
  logic             mmcm_rst;
  logic             mmcm_locked = 1'b1;

  mmcm_drp_sequencer #(.pDEPTH(DEPTH), .pIDX_W(IDX_W), .pTMO_W(TMO_W)) dut (
    .clk_usb(clk_usb), .reset_i(reset_i), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_mask(tbl_mask), .tbl_data(tbl_data), .cfg_count(cfg_count),
    .start(start), .busy(busy), .done(done), .error(error), .err_code(err_code),
    .drp_addr(drp_addr), .drp_din(drp_din), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_dout(drp_dout), .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
  );

  always #20 clk_usb = ~clk_usb;

  int cyc = 0;
  always @(posedge clk_usb) cyc <= cyc + 1;

  typedef struct {bit we; logic [6:0] addr; logic [15:0] din;} op_t;
  typedef struct {int count; int exp_ops; int dmode; int dfix;} vec_t;

  logic [15:0] mmcm_mem [128];
  logic [15:0] ref_mem [128];
  drp_entry_t  sh_tbl [DEPTH];
  op_t         obs[$];

  int dmode = 1, dfix = 1, dk = 0;
  bit wr_stall = 0, lock_stuck = 0, in_run = 0;
  bit pend = 0, pend_we = 0, den_prev = 0, rst_prev = 0;
  int pend_cnt = 0;
  logic [6:0]  pend_addr = '0;
  logic [15:0] pend_din = '0;
  int b2b_err = 0, stab_err = 0, norst_err = 0, overlap_err = 0, busy_gap = 0;
  int rst_len = 0, last_rst_len = 0, rst_rise_cyc = -1, rst_fall_cyc = -1;
  int first_den_cyc = -1, last_drdy_cyc = -1, last_wr_den_cyc = -1, start_cyc = 0;
  int lock_cnt = 100;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int next_delay();
    int r;
    case (dmode)
      0:       r = (dk % 3 == 0) ? 1 : ((dk % 3 == 1) ? 4 : 7);
      1:       r = dfix;
      default: r = int'($urandom_range(7, 1));
    endcase
    dk++;
    return r;
  endfunction

  // DRP slave + MMCM lock model, plus protocol monitors, all evaluated on the falling edge.
  initial begin
    op_t o;
    forever begin
      @(negedge clk_usb);
      if (reset_i) begin
        pend = 0; drp_drdy = 1'b0; den_prev = 0; rst_prev = 0; rst_len = 0;
      end else begin
        drp_drdy = 1'b0;
        if (pend) begin
          if (drp_addr !== pend_addr || (pend_we && drp_din !== pend_din)) stab_err++;
          pend_cnt--;
          if (pend_cnt <= 0) begin
            drp_drdy = 1'b1;
            if (!pend_we) drp_dout = mmcm_mem[pend_addr];
            pend = 0;
            last_drdy_cyc = cyc;
          end
        end
        if (drp_den) begin
          if (den_prev) b2b_err++;
          if (!mmcm_rst) norst_err++;
          if (pend) overlap_err++;
          o.we = drp_dwe; o.addr = drp_addr; o.din = drp_din;
          obs.push_back(o);
          if (first_den_cyc < 0) first_den_cyc = cyc;
          if (drp_dwe) begin
            mmcm_mem[drp_addr] = drp_din;
            last_wr_den_cyc = cyc;
          end
          if (!(drp_dwe && wr_stall)) begin
            pend = 1; pend_we = drp_dwe; pend_addr = drp_addr; pend_din = drp_din;
            pend_cnt = next_delay();
          end
        end
        den_prev = drp_den;
        if (mmcm_rst) begin
          mmcm_locked = 1'b0; lock_cnt = 0; rst_len++;
          if (!rst_prev && rst_rise_cyc < 0) rst_rise_cyc = cyc;
        end else begin
          if (rst_prev) begin last_rst_len = rst_len; rst_fall_cyc = cyc; end
          rst_len = 0;
          if (!lock_stuck) begin
            lock_cnt++;
            if (lock_cnt >= 5) mmcm_locked = 1'b1;
          end
        end
        rst_prev = mmcm_rst;
        if (in_run && !busy && !done && !error) busy_gap++;
      end
    end
  end

  task automatic tbl_write(input int i, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
    @(negedge clk_usb);
    tbl_we = 1'b1; tbl_idx = IDX_W'(i); tbl_addr = a; tbl_mask = m; tbl_data = d;
    @(negedge clk_usb);
    tbl_we = 1'b0;
    sh_tbl[i] = '{addr: a, mask: m, data: d};
  endtask

  task automatic resync_ref();
    for (int a = 0; a < 128; a++) ref_mem[a] = mmcm_mem[a];
  endtask

  // variant: 0 normal, 1 start with coincident tbl_we, 2 start/tbl_we during busy,
  // 3 reset in WR_WAIT, 4 write DRDY never returns, 5 lock never returns.
  task automatic run_seq(input int count, input int exp_ops, input int dm, input int df,
                         input int variant, input string label);
    op_t expq[$];
    op_t e;
    int n, to, limit;
    logic [6:0]  a;
    logic [15:0] v, cm, cd;
    logic [6:0]  ca;
    dmode = dm; dfix = df; dk = 0;
    ca = 7'($urandom_range(15, 0)); cm = 16'($urandom); cd = 16'($urandom);
    if (variant == 1) sh_tbl[0] = '{addr: ca, mask: cm, data: cd};
    n = (count > DEPTH) ? DEPTH : count;
    for (int i = 0; i < n; i++) begin
      a = sh_tbl[i].addr;
      v = (ref_mem[a] & sh_tbl[i].mask) | (sh_tbl[i].data & ~sh_tbl[i].mask);
      e.we = 0; e.addr = a; e.din = '0; expq.push_back(e);
      e.we = 1; e.addr = a; e.din = v;  expq.push_back(e);
      ref_mem[a] = v;
    end
    obs.delete();
    b2b_err = 0; stab_err = 0; norst_err = 0; overlap_err = 0; busy_gap = 0;
    rst_rise_cyc = -1; rst_fall_cyc = -1; first_den_cyc = -1; last_rst_len = 0;

    @(negedge clk_usb);
    cfg_count = (IDX_W + 1)'(count);
    start = 1'b1;
    if (variant == 1) begin
      tbl_we = 1'b1; tbl_idx = '0; tbl_addr = ca; tbl_mask = cm; tbl_data = cd;
    end
    @(negedge clk_usb);
    start = 1'b0; tbl_we = 1'b0;
    start_cyc = cyc;
    in_run = 1;
    chk({label, "_busy_set"}, busy, 1);
    chk({label, "_done_clear"}, done, 0);

    if (variant == 2) begin
      repeat (6) @(negedge clk_usb);
      start = 1'b1; cfg_count = '0;
      tbl_we = 1'b1; tbl_idx = '0; tbl_addr = 7'h7F; tbl_mask = 16'h0000; tbl_data = 16'hDEAD;
      @(negedge clk_usb);
      start = 1'b0; tbl_we = 1'b0;
    end

    if (variant == 3) begin
      to = 0;
      while (!(obs.size() > 0 && obs[obs.size()-1].we) && to < 500) begin
        @(negedge clk_usb); to++;
      end
      chk({label, "_reached_wr_wait"}, (to < 500), 1);
      in_run = 0;
      reset_i = 1'b1;
      #1;
      chk({label, "_outputs_zero"},
          {busy, done, error, err_code, drp_den, drp_dwe, mmcm_rst, drp_addr, drp_din}, 0);
      @(negedge clk_usb);
      @(negedge clk_usb);
      reset_i = 1'b0;
      resync_ref();
      $display("run %s: reset applied after %0d DRP ops", label, obs.size());
      return;
    end

    limit = (variant >= 4) ? 4000 : 2000;
    to = 0;
    while (busy && to < limit) begin
      @(negedge clk_usb); to++;
    end
    in_run = 0;
    chk({label, "_busy_released"}, busy, 0);

    if (variant == 4) begin
      chk({label, "_error"}, error, 1);
      chk({label, "_err_code"}, err_code, ERR_WR_TMO);
      chk({label, "_mmcm_rst"}, mmcm_rst, 0);
      chk({label, "_done"}, done, 0);
      chk({label, "_ops"}, obs.size(), exp_ops);
      chk({label, "_delay_ok"}, (cyc - last_wr_den_cyc >= 1020 && cyc - last_wr_den_cyc <= 1028), 1);
      wr_stall = 0;
      resync_ref();
    end else if (variant == 5) begin
      chk({label, "_error"}, error, 1);
      chk({label, "_err_code"}, err_code, ERR_LOCK_TMO);
      chk({label, "_mmcm_rst"}, mmcm_rst, 0);
      chk({label, "_done"}, done, 0);
      chk({label, "_delay_ok"}, (cyc - rst_fall_cyc >= 1020 && cyc - rst_fall_cyc <= 1028), 1);
      lock_stuck = 0;
    end else begin
      chk({label, "_ops"}, obs.size(), exp_ops);
      for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
        chk($sformatf("%s_op%0d_we", label, i), obs[i].we, expq[i].we);
        chk($sformatf("%s_op%0d_addr", label, i), obs[i].addr, expq[i].addr);
        if (expq[i].we) chk($sformatf("%s_op%0d_din", label, i), obs[i].din, expq[i].din);
      end
      chk({label, "_done"}, done, 1);
      chk({label, "_error"}, {error, err_code}, 0);
      chk({label, "_mmcm_rst_low"}, mmcm_rst, 0);
      chk({label, "_locked_at_done"}, mmcm_locked, 1);
      chk({label, "_protocol"}, b2b_err + stab_err + norst_err + overlap_err, 0);
      chk({label, "_busy_gap"}, busy_gap, 0);
      chk({label, "_rst_hold_ge3"}, (last_rst_len >= 3), 1);
      if (n > 0) begin
        chk({label, "_start_to_den"}, first_den_cyc - start_cyc, 2);
        chk({label, "_rst_before_rd"}, (rst_rise_cyc >= 0 && rst_rise_cyc < first_den_cyc), 1);
        chk({label, "_rst_after_wr"}, (rst_fall_cyc > last_drdy_cyc), 1);
      end
    end
    $display("run %s: count=%0d ops=%0d done=%0b error=%0b err_code=%0d",
             label, count, obs.size(), done, error, err_code);
  endtask

  vec_t vecs[7];

  initial begin
    int c;
    vecs[0] = '{count: 1,  exp_ops: 2,  dmode: 1, dfix: 1};
    vecs[1] = '{count: 3,  exp_ops: 6,  dmode: 0, dfix: 0};
    vecs[2] = '{count: 0,  exp_ops: 0,  dmode: 1, dfix: 1};
    vecs[3] = '{count: 8,  exp_ops: 16, dmode: 1, dfix: 2};
    vecs[4] = '{count: 12, exp_ops: 16, dmode: 2, dfix: 0};
    vecs[5] = '{count: 15, exp_ops: 16, dmode: 1, dfix: 1};
    vecs[6] = '{count: 5,  exp_ops: 10, dmode: 2, dfix: 0};

    for (int a = 0; a < 128; a++) begin
      mmcm_mem[a] = 16'($urandom);
      ref_mem[a]  = mmcm_mem[a];
    end
    mmcm_mem[8] = 16'h1FFF;
    ref_mem[8]  = 16'h1FFF;

    repeat (3) @(negedge clk_usb);
    chk("reset_outputs",
        {busy, done, error, err_code, drp_den, drp_dwe, mmcm_rst, drp_addr, drp_din}, 0);
    reset_i = 1'b0;

    tbl_write(0, 7'h08, 16'h1000, 16'h0145);
    for (int i = 1; i < DEPTH; i++)
      tbl_write(i, 7'($urandom_range(15, 0)), 16'($urandom), 16'($urandom));

    for (int vi = 0; vi < 7; vi++) begin
      run_seq(vecs[vi].count, vecs[vi].exp_ops, vecs[vi].dmode, vecs[vi].dfix, 0,
              $sformatf("vec%0d", vi));
      if (vi == 0) begin
        if (obs.size() >= 2) chk("single_rmw_din", obs[1].din, 16'h1145);
        else chk("single_rmw_ops", obs.size(), 2);
      end
    end

    run_seq(2, 4, 2, 0, 1, "coincide_we");
    run_seq(3, 6, 1, 7, 2, "busy_ignore");
    run_seq(1, 2, 1, 1, 0, "after_ignore");

    for (int r = 0; r < 6; r++) begin
      tbl_write(int'($urandom_range(DEPTH - 1, 0)), 7'($urandom_range(15, 0)), 16'($urandom), 16'($urandom));
      tbl_write(int'($urandom_range(DEPTH - 1, 0)), 7'($urandom_range(15, 0)), 16'($urandom), 16'($urandom));
      c = int'($urandom_range(15, 0));
      run_seq(c, 2 * ((c > DEPTH) ? DEPTH : c), 2, 0, 0, $sformatf("rand%0d", r));
    end

    run_seq(4, 0, 1, 7, 3, "abort");
    run_seq(2, 4, 2, 0, 0, "after_abort");

`ifdef SONATA_DRP_SEQ_TIMEOUT_EN
    wr_stall = 1;
    run_seq(2, 2, 1, 1, 4, "tmo_wr");
    lock_stuck = 1;
    run_seq(0, 0, 1, 1, 5, "tmo_lock");
    repeat (10) @(negedge clk_usb);
    run_seq(1, 2, 1, 1, 0, "after_tmo");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
